eth_tx_stream_arbiter: RTL and testbench
========================================

# eth_tx_stream_arbiter

Packet-level round-robin arbiter that shares the 32-bit Avalon-ST transmit path (the MAC-side timing adapter and everything downstream of it) between NUM_IN packet sources. Ownership is granted only at a start-of-packet and held until the matching end-of-packet, so packets from different sources never interleave. Output is a single registered stage with full Avalon-ST ready/valid backpressure, ready latency 0.

## Interface
Parameters:
- NUM_IN, 2: number of requesting streams, legal 2..4.
- DATA_W, 32: symbol-packed data width.
- EMPTY_W, 2: width of the empty field.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  NUM_IN  per-source valid.
- in_ready  out  NUM_IN  per-source ready (combinational).
- in_data  in  NUM_IN*DATA_W  source i at bits [i*DATA_W +: DATA_W].
- in_startofpacket  in  NUM_IN  per-source SOP.
- in_endofpacket  in  NUM_IN  per-source EOP.
- in_empty  in  NUM_IN*EMPTY_W  source i at [i*EMPTY_W +: EMPTY_W].
- out_ready  in  1  downstream ready.
- out_valid  out  1  registered.
- out_data  out  DATA_W  registered.
- out_startofpacket  out  1  registered.
- out_endofpacket  out  1  registered.
- out_empty  out  EMPTY_W  registered; meaningful only with EOP.
- grant  out  NUM_IN  one-hot current owner, all-zero in IDLE.
- err_orphan  out  NUM_IN  one-cycle pulse per source when a non-SOP beat is discarded.

## Operation
- States: IDLE, LOCKED. Registers: state, grant (one-hot), last (index of the last owner), output stage, err_orphan.
- Request i = in_valid[i] & in_startofpacket[i].
- IDLE: if any request, grant <= first requester searching last+1, last+2, … modulo NUM_IN; state <= LOCKED. No beat is accepted in IDLE.
- LOCKED: load = !out_valid | out_ready. in_ready[g] = load for the owner g; the transfer occurs when in_valid[g] & in_ready[g]. On transfer the output stage captures data, SOP, EOP and empty from source g, and out_valid <= 1. Otherwise, if out_ready, out_valid <= 0.
- A transfer with EOP: state <= IDLE, last <= g, grant <= 0, all on the same edge.
- SOP without EOP from the owner mid-packet is passed through unchanged. It is not checked.
- Orphan discard, in either state: a non-owner with in_valid=1 and in_startofpacket=0 gets in_ready=1. The beat is dropped and err_orphan[i] pulses on the next cycle. A non-owner presenting an SOP is held with in_ready=0 and is never dropped.
- Single-beat packet (SOP and EOP together): LOCKED for exactly one transfer, then IDLE.

## Timing
- Reset values: state=IDLE, grant=0, last=NUM_IN-1 (source 0 wins first), out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, err_orphan=0. in_ready is 0 for any source that is valid with SOP asserted.
- Latency: request seen in cycle 0 → grant in cycle 1 → first beat accepted at the end of cycle 1 (if load=1) → out_valid in cycle 2.
- Throughput: 1 beat/cycle within a packet while out_ready=1. There is exactly one IDLE cycle between consecutive packets, including back-to-back packets from the same source.
- Backpressure: while out_valid=1 and out_ready=0, the output holds stable and the owner's in_ready=0. No beat is lost or duplicated.
- Simultaneous requests: resolved strictly round-robin from last+1. A source that just finished cannot win again while another source is requesting.
- The owner dropping in_valid mid-packet keeps the lock indefinitely. No timeout.
- Reset asserted mid-packet: everything returns to reset values on the next edge and the in-flight packet is truncated. The downstream path must be reset together with this block.

## Test plan
- Single source: source 0 sends 4 beats 0xA0..0xA3 (SOP on the first, EOP plus empty=2 on the last) with out_ready=1. out_valid is first high 2 cycles after SOP, the beats appear consecutively with SOP/EOP/empty intact, and grant returns to 0 after the EOP transfer.
- Fairness: both sources hold continuous 2-beat packets. Outputs alternate 0,1,0,1 with one idle cycle between packets and never interleave.
- Backpressure: out_ready toggles 1,0,0,1 during a 3-beat packet. The output is stable while stalled, in_ready[g]=0 during the stall, and the beat sequence arrives unchanged.
- Orphan: source 1 presents a non-SOP beat 0xDEAD while source 0 owns the path. in_ready[1]=1, err_orphan[1] pulses for exactly one cycle, and 0xDEAD never appears on out_data.
- Single-beat packets: sources 0 and 1 each send SOP+EOP beats. Each produces one output beat, and state returns to IDLE after every beat.
- Reset mid-packet: assert reset after the 2nd beat of a 5-beat packet. Next cycle out_valid=0, grant=0, and a following request from source 1 is served first only if source 0 is not also requesting (source 0 wins after reset).

Source files
------------

// File: rtl/eth_tx_stream_arbiter.sv
// Purpose : packet-level round-robin arbiter sharing one Avalon-ST TX path between NUM_IN sources.
// Latency : SOP seen in cycle 0, grant in cycle 1, beat on out_valid in cycle 2; one IDLE cycle between packets.
// Backpres: owner in_ready = !out_valid | out_ready (ready latency 0); stray non-SOP beats from non-owners are drained.
module eth_tx_stream_arbiter #(
  parameter int NUM_IN  = 2,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_startofpacket,
  input  logic [NUM_IN-1:0]         in_endofpacket,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [NUM_IN-1:0]         grant,
  output logic [NUM_IN-1:0]         err_orphan
);

  localparam int IDX_W = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;

  logic [NUM_IN-1:0]  req;
  logic [NUM_IN-1:0]  pick_oh;
  logic               pick_found;

  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_sop;
  logic               sel_eop;
  logic [EMPTY_W-1:0] sel_empty;
  logic [IDX_W-1:0]   owner_idx;

  logic               load;
  logic               xfer;
  logic [NUM_IN-1:0]  orphan;

  // Round-robin pick among SOP requesters, searching from the source after the last owner.
  always_comb begin
    req        = in_valid & in_startofpacket;
    pick_found = 1'b0;
    pick_oh    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!pick_found && req[i] && (i == (int'(last) + k) % NUM_IN)) begin
          pick_found = 1'b1;
          pick_oh[i] = 1'b1;
        end
      end
    end
  end

  // One-hot select of the owner's beat; grant is all-zero outside LOCKED so nothing is selected in IDLE.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_empty = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        sel_valid = in_valid[i];
        sel_data  = in_data[i*DATA_W +: DATA_W];
        sel_sop   = in_startofpacket[i];
        sel_eop   = in_endofpacket[i];
        sel_empty = in_empty[i*EMPTY_W +: EMPTY_W];
        owner_idx = IDX_W'(i);
      end
    end
  end

  // Handshake: owner follows the output stage; non-owner non-SOP beats are swallowed, SOPs are held off.
  always_comb begin
    load     = !out_valid || out_ready;
    orphan   = in_valid & ~in_startofpacket & ~grant;
    in_ready = orphan | (grant & {NUM_IN{load}});
    xfer     = (state == LOCKED) && sel_valid && load;
  end

  // Arbitration FSM together with the registered output stage and orphan flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      grant             <= '0;
      last              <= IDX_W'(NUM_IN - 1);
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      err_orphan        <= '0;
    end else begin
      err_orphan <= orphan;

      if (xfer) begin
        out_valid         <= 1'b1;
        out_data          <= sel_data;
        out_startofpacket <= sel_sop;
        out_endofpacket   <= sel_eop;
        out_empty         <= sel_empty;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= LOCKED;
            grant <= pick_oh;
          end
        end
        LOCKED: begin
          // Ownership ends on the EOP transfer; mid-packet SOPs from the owner pass straight through.
          if (xfer && sel_eop) begin
            state <= IDLE;
            grant <= '0;
            last  <= owner_idx;
          end
        end
      endcase
    end
  end

  // Ownership is a single source, and exists only while LOCKED.
  assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  assert property (@(posedge clk) disable iff (reset) ((state == LOCKED) == (grant != '0)));

endmodule

// File: tb/tb_eth_tx_stream_arbiter.sv
// Purpose : directed bench for eth_tx_stream_arbiter with a cycle model and a beat scoreboard.
// Latency : inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpres: source drivers honour in_ready; out_ready is scripted per test.
`timescale 1ns/1ps
module tb_eth_tx_stream_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int EW = 2;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
  } beat_t;

  logic          clk;
  logic          reset;
  logic [N-1:0]  in_valid, in_ready, in_sop, in_eop;
  logic [N*DW-1:0] in_data;
  logic [N*EW-1:0] in_empty;
  logic          out_ready, out_valid, out_sop, out_eop;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_empty;
  logic [N-1:0]  grant, err_orphan;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  beat_t srcq [N][$];
  int    acc_cnt [N];
  beat_t obs [$];
  int    obs_cyc [$];
  int    err_cnt [N];
  int    stall_cyc = 0;
  int    stall_rdy_bad = 0;

  // Behavioural model of the arbiter: ownership, last winner and the output register contents.
  bit          mv = 0;
  bit          m_locked;
  int          m_owner;
  int          m_last;
  logic        m_ov, m_osop, m_oeop;
  logic [31:0] m_od;
  logic [1:0]  m_oemp;
  logic [N-1:0] m_err;

  eth_tx_stream_arbiter #(.NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_empty         (out_empty),
    .grant             (grant),
    .err_orphan        (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int s, input logic [31:0] d, input logic sop, input logic eop,
                      input logic [1:0] emp);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop; b.emp = emp;
    srcq[s].push_back(b);
  endtask

  task automatic push_pkt(input int s, input logic [31:0] base, input int n, input logic [1:0] emp);
    for (int k = 0; k < n; k++)
      push(s, base + 32'(k), k == 0, k == n - 1, (k == n - 1) ? emp : 2'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (srcq[0].size() == 0 && srcq[1].size() == 0 && in_valid == '0 && !out_valid && grant == '0)
        done = 1;
    end
    chk({name, "_drain"}, 32'(done), 32'd1);
    tick(1);
  endtask

  task automatic wait_grant(input string name, input int s, input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (grant[s]) done = 1;
    end
    chk({name, "_grant"}, 32'(done), 32'd1);
  endtask

  // Source drivers: present each queue head until the arbiter accepts it.
  initial begin : drivers
    logic [N-1:0] acc;
    beat_t        tmp;
    in_valid = '0; in_data = '0; in_sop = '0; in_eop = '0; in_empty = '0;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready & {N{~reset}};
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && srcq[i].size() > 0) begin
          tmp = srcq[i].pop_front();
          acc_cnt[i]++;
        end
        if (srcq[i].size() > 0) begin
          tmp = srcq[i][0];
          in_valid[i] = 1'b1;
          in_data[i*DW +: DW] = tmp.d;
          in_sop[i] = tmp.sop;
          in_eop[i] = tmp.eop;
          in_empty[i*EW +: EW] = tmp.emp;
        end else begin
          in_valid[i] = 1'b0;
          in_data[i*DW +: DW] = '0;
          in_sop[i] = 1'b0;
          in_eop[i] = 1'b0;
          in_empty[i*EW +: EW] = '0;
        end
      end
    end
  end

  // Compare process: every cycle check the DUT against the model, then advance the model.
  initial begin : monitor
    logic         load;
    logic [N-1:0] exp_rdy, exp_grant, nerr;
    bit           take;
    int           c;
    beat_t        b;
    forever begin
      @(negedge clk);
      load = !m_ov || out_ready;
      exp_rdy = '0;
      exp_grant = '0;
      for (int i = 0; i < N; i++) begin
        if (m_locked && m_owner == i) begin
          exp_rdy[i] = load;
          exp_grant[i] = 1'b1;
        end else begin
          exp_rdy[i] = in_valid[i] && !in_sop[i];
        end
      end
      if (mv) begin
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", out_data, m_od);
        chk("out_sop", 32'(out_sop), 32'(m_osop));
        chk("out_eop", 32'(out_eop), 32'(m_oeop));
        chk("out_empty", 32'(out_empty), 32'(m_oemp));
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("err_orphan", 32'(err_orphan), 32'(m_err));
      end
      if (!reset) begin
        if (out_valid && out_ready) begin
          b.d = out_data; b.sop = out_sop; b.eop = out_eop; b.emp = out_empty;
          obs.push_back(b);
          obs_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) if (err_orphan[i]) err_cnt[i]++;
        if (out_valid && !out_ready) begin
          stall_cyc++;
          if ((in_ready & grant) != '0) stall_rdy_bad++;
        end
      end
      if (reset) begin
        mv = 1; m_locked = 0; m_owner = 0; m_last = N - 1;
        m_ov = 0; m_od = '0; m_osop = 0; m_oeop = 0; m_oemp = '0; m_err = '0;
      end else begin
        nerr = '0;
        for (int i = 0; i < N; i++)
          if (!(m_locked && m_owner == i) && in_valid[i] && !in_sop[i]) nerr[i] = 1'b1;
        take = m_locked && in_valid[m_owner] && load;
        if (take) begin
          m_ov = 1'b1;
          m_od = in_data[m_owner*DW +: DW];
          m_osop = in_sop[m_owner];
          m_oeop = in_eop[m_owner];
          m_oemp = in_empty[m_owner*EW +: EW];
        end else if (out_ready) begin
          m_ov = 1'b0;
        end
        if (m_locked) begin
          if (take && in_eop[m_owner]) begin
            m_locked = 0;
            m_last = m_owner;
          end
        end else begin
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!m_locked && in_valid[c] && in_sop[c]) begin
              m_locked = 1;
              m_owner = c;
            end
          end
        end
        m_err = nerr;
      end
    end
  end

  initial begin : tests
    int          pc, base, dead, e0, e1, sc, sb;
    bit          done;
    logic [31:0] fair_exp [12];

    reset = 1'b1;
    out_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    tick(1);

    // Single source, 4 beats, empty=2 on EOP.
    obs.delete(); obs_cyc.delete();
    pc = cyc;
    push_pkt(0, 32'hA0, 4, 2'd2);
    wait_drain("single", 60);
    chk("single_count", 32'(obs.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("single_beat%0d", k), (k < obs.size()) ? obs[k].d : 32'hFFFF_FFFF, 32'hA0 + 32'(k));
    if (obs.size() == 4) begin
      chk("single_sop_first", 32'(obs[0].sop), 32'd1);
      chk("single_sop_second", 32'(obs[1].sop), 32'd0);
      chk("single_eop_last", 32'(obs[3].eop), 32'd1);
      chk("single_empty_last", 32'(obs[3].emp), 32'd2);
      chk("single_first_latency", 32'(obs_cyc[0] - (pc + 1)), 32'd2);
      chk("single_back_to_back", 32'(obs_cyc[3] - obs_cyc[0]), 32'd3);
    end

    // Fairness: both sources stream 2-beat packets; source 1 goes first since source 0 owned last.
    obs.delete(); obs_cyc.delete();
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 32'h100 + 32'(16 * p), 2, 2'd0);
      push_pkt(1, 32'h200 + 32'(16 * p), 2, 2'd0);
    end
    fair_exp = '{32'h200, 32'h201, 32'h100, 32'h101, 32'h210, 32'h211,
                 32'h110, 32'h111, 32'h220, 32'h221, 32'h120, 32'h121};
    wait_drain("fair", 120);
    chk("fair_count", 32'(obs.size()), 32'd12);
    for (int k = 0; k < 12; k++)
      chk($sformatf("fair_beat%0d", k), (k < obs.size()) ? obs[k].d : 32'hFFFF_FFFF, fair_exp[k]);
    for (int k = 0; k + 1 < obs_cyc.size(); k++)
      chk($sformatf("fair_gap%0d", k), 32'(obs_cyc[k+1] - obs_cyc[k]), (k % 2 == 0) ? 32'd1 : 32'd2);

    // Backpressure: out_ready 1,0,0,1 while a 3-beat packet is in flight.
    obs.delete(); obs_cyc.delete();
    sc = stall_cyc; sb = stall_rdy_bad;
    push_pkt(0, 32'h300, 3, 2'd1);
    tick(4);
    out_ready = 1'b0;
    tick(2);
    out_ready = 1'b1;
    wait_drain("bp", 60);
    chk("bp_count", 32'(obs.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_beat%0d", k), (k < obs.size()) ? obs[k].d : 32'hFFFF_FFFF, 32'h300 + 32'(k));
    if (obs.size() == 3) chk("bp_empty_last", 32'(obs[2].emp), 32'd1);
    chk("bp_stall_cycles", 32'(stall_cyc - sc), 32'd2);
    chk("bp_owner_ready_in_stall", 32'(stall_rdy_bad - sb), 32'd0);

    // Orphan: source 1 shows a non-SOP beat while source 0 owns the path.
    obs.delete(); obs_cyc.delete();
    e0 = err_cnt[0]; e1 = err_cnt[1];
    push_pkt(0, 32'h400, 3, 2'd0);
    wait_grant("orphan", 0, 20);
    tick(1);
    push(1, 32'hDEAD, 1'b0, 1'b0, 2'd0);
    tick(1);
    @(negedge clk);
    chk("orphan_ready", 32'(in_ready[1]), 32'd1);
    wait_drain("orphan", 60);
    chk("orphan_pulses_src1", 32'(err_cnt[1] - e1), 32'd1);
    chk("orphan_pulses_src0", 32'(err_cnt[0] - e0), 32'd0);
    chk("orphan_count", 32'(obs.size()), 32'd3);
    dead = 0;
    foreach (obs[k]) if (obs[k].d == 32'hDEAD) dead++;
    chk("orphan_not_forwarded", 32'(dead), 32'd0);

    // Single-beat packets from both sources; source 1 wins first after source 0 owned last.
    obs.delete(); obs_cyc.delete();
    push(0, 32'h500, 1'b1, 1'b1, 2'd3);
    push(1, 32'h501, 1'b1, 1'b1, 2'd0);
    wait_drain("sbeat", 40);
    chk("sbeat_count", 32'(obs.size()), 32'd2);
    if (obs.size() == 2) begin
      chk("sbeat_first", obs[0].d, 32'h501);
      chk("sbeat_second", obs[1].d, 32'h500);
      chk("sbeat_second_empty", 32'(obs[1].emp), 32'd3);
      chk("sbeat_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd2);
    end

    // Reset mid-packet: source 0 owned last, but reset restores source 0 as first winner.
    push(0, 32'h600, 1'b1, 1'b1, 2'd0);
    wait_drain("rst_pre", 40);
    base = acc_cnt[0];
    push_pkt(0, 32'h700, 5, 2'd0);
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick(1);
      if (acc_cnt[0] == base + 2) done = 1;
    end
    chk("rst_mid_two_beats", 32'(done), 32'd1);
    reset = 1'b1;
    srcq[0].delete();
    srcq[1].delete();
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_grant", 32'(grant), 32'd0);
    tick(1);
    obs.delete(); obs_cyc.delete();
    push(1, 32'h801, 1'b1, 1'b1, 2'd0);
    push(0, 32'h800, 1'b1, 1'b1, 2'd0);
    wait_drain("rst_post", 40);
    chk("rst_post_count", 32'(obs.size()), 32'd2);
    if (obs.size() == 2) begin
      chk("rst_post_first", obs[0].d, 32'h800);
      chk("rst_post_second", obs[1].d, 32'h801);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
